instr_fetch_stage: RTL

//  Fetch stage of the pipelined RV64 core: owns the PC, issues one-outstanding reads to

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/instr_fetch_stage_if.sv | 14 +
 rtl/if_id_pipe_reg.sv | 36 +++
 rtl/instr_fetch_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: widths, the canonical NOP, base opcodes and the
// fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and imem (slave).
interface instr_fetch_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  // imem_req=1 means imem_addr is accepted that same cycle (no ready signal);
  // exactly one imem_rvalid pulse with imem_rdata answers it one or more cycles later.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, stall holds contents.
module if_id_pipe_reg #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic            stall,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      valid <= 1'b1;
    end else if (!stall) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// RV64 fetch stage: PC, one-outstanding imem reads, 1-entry skid for ID stalls,
// EX redirects with wrong-path squashing, and the IF/ID register.
module instr_fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  instr_fetch_stage_if.master     imem,
  output logic [XLEN-1:0]         if_id_pc,
  output logic [31:0]             if_id_instr,
  output logic                    if_id_valid,
  output riscv_pkg::fetch_state_e dbg_state,
  output logic                    dbg_skid_valid
);
  import riscv_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            skid_valid;

  logic            if_id_free;
  logic            pipe_load;
  logic [XLEN-1:0] pipe_pc;
  logic [31:0]     pipe_instr;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = &redirect_pc[1:0];
  assign if_id_free          = !if_id_valid || !stall;

  // A redirect in S_REQ suppresses the request so the old-path read never leaves.
  assign imem.imem_req  = (state == S_REQ) && !reset && !redirect_valid;
  assign imem.imem_addr = pc;

  assign dbg_state      = state;
  assign dbg_skid_valid = skid_valid;

  always_comb begin
    pipe_load  = 1'b0;
    pipe_pc    = pc;
    pipe_instr = imem.imem_rdata;
    if (state == S_WAIT && imem.imem_rvalid && if_id_free) begin
      pipe_load = 1'b1;
    end else if (state == S_FULL && !stall) begin
      pipe_load  = 1'b1;
      pipe_pc    = skid_pc;
      pipe_instr = skid_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc         <= {redirect_pc[XLEN-1:2], 2'b00};
      skid_valid <= 1'b0;
      case (state)
        S_WAIT, S_DROP: state <= imem.imem_rvalid ? S_REQ : S_DROP;
        default:        state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            pc <= pc + XLEN'(4);
            if (if_id_free) begin
              state <= S_REQ;
            end else begin
              skid_pc    <= pc;
              skid_instr <= imem.imem_rdata;
              skid_valid <= 1'b1;
              state      <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            skid_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_pipe_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .load       (pipe_load),
    .stall      (stall),
    .load_pc    (pipe_pc),
    .load_instr (pipe_instr),
    .pc         (if_id_pc),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule
